// File: rtl/bin2bcd_4digit.sv
// Sequential shift-add-3 binary-to-BCD converter for the 4-digit 7-segment driver.
// One conversion takes IN_WIDTH shift cycles. Values above 9999 are shown as all-F digits.
module bin2bcd_4digit #(
    parameter int IN_WIDTH = 14
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [IN_WIDTH-1:0] BIN_IN,
    output logic                BUSY,
    output logic                DONE,
    output logic                OVF,
    output logic [3:0]          D3,
    output logic [3:0]          D2,
    output logic [3:0]          D1,
    output logic [3:0]          D0
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(IN_WIDTH - 1);

    state_t                state_reg,  state_next;
    logic [IN_WIDTH-1:0]   bin_sr_reg, bin_sr_next;
    logic [15:0]           bcd_sr_reg, bcd_sr_next;
    logic [3:0]            cnt_reg,    cnt_next;
    logic                  ovf_q_reg,  ovf_q_next;
    logic                  busy_reg,   busy_next;
    logic                  done_reg,   done_next;
    logic                  ovf_reg,    ovf_next;
    logic [15:0]           digits_reg, digits_next;

    logic [15:0]           bcd_adj;
    logic [15:0]           bcd_shifted;
    logic [IN_WIDTH-1:0]   bin_shifted;
    logic                  bin_too_big;

    // Add-3 correction on every BCD nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = bcd_sr_reg[gi*4 +: 4];
            assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    endgenerate

    // The corrected BCD MSB falls off the top; it is always zero for legal widths.
    assign {bcd_shifted, bin_shifted} = {bcd_adj, bin_sr_reg} << 1;

    // Zero-extend before comparing so narrow widths never truncate the constant.
    assign bin_too_big = ({{(32 - IN_WIDTH){1'b0}}, BIN_IN} > 32'd9999);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg  <= ST_IDLE;
            bin_sr_reg <= '0;
            bcd_sr_reg <= '0;
            cnt_reg    <= '0;
            ovf_q_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            digits_reg <= '0;
        end else begin
            state_reg  <= state_next;
            bin_sr_reg <= bin_sr_next;
            bcd_sr_reg <= bcd_sr_next;
            cnt_reg    <= cnt_next;
            ovf_q_reg  <= ovf_q_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            ovf_reg    <= ovf_next;
            digits_reg <= digits_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bin_sr_next = bin_sr_reg;
        bcd_sr_next = bcd_sr_reg;
        cnt_next    = cnt_reg;
        ovf_q_next  = ovf_q_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        ovf_next    = ovf_reg;
        digits_next = digits_reg;

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    bin_sr_next = BIN_IN;
                    bcd_sr_next = '0;
                    ovf_q_next  = bin_too_big;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    state_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_sr_next = bcd_shifted;
                bin_sr_next = bin_shifted;
                cnt_next    = cnt_reg + 4'd1;
                if (cnt_reg == LAST_CNT) begin
                    state_next  = ST_IDLE;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    ovf_next    = ovf_q_reg;
                    digits_next = ovf_q_reg ? 16'hFFFF : bcd_shifted;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign BUSY = busy_reg;
    assign DONE = done_reg;
    assign OVF  = ovf_reg;
    assign D3   = digits_reg[15:12];
    assign D2   = digits_reg[11:8];
    assign D1   = digits_reg[7:4];
    assign D0   = digits_reg[3:0];

endmodule

// File: tb/tb_bin2bcd_4digit.sv
// Self-checking bench for bin2bcd_4digit: table of directed conversions plus
// hand-written sequences for START-while-busy, mid-conversion reset and back-to-back.
module tb_bin2bcd_4digit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [13:0] BIN_IN = '0;
    logic        BUSY, DONE, OVF;
    logic [3:0]  D3, D2, D1, D0;

    bin2bcd_4digit #(.IN_WIDTH(14)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BIN_IN(BIN_IN),
        .BUSY(BUSY), .DONE(DONE), .OVF(OVF),
        .D3(D3), .D2(D2), .D1(D1), .D0(D0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] digits();
        return {D3, D2, D1, D0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Accepting edge, then scramble BIN_IN to prove the value was captured.
    task automatic start_conv(input logic [13:0] v);
        START  = 1'b1;
        BIN_IN = v;
        tick();
        START  = 1'b0;
        BIN_IN = ~v;
    endtask

    task automatic run_vec(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
        int   lat;
        logic busy_ok;
        start_conv(v);
        check("busy_rise", {31'd0, BUSY}, 32'd1);
        lat = 0;
        busy_ok = 1'b1;
        while (1) begin
            tick();
            lat++;
            if (DONE) break;
            if (!BUSY) busy_ok = 1'b0;
            if (lat >= 40) break;
        end
        check("latency", lat, 32'd14);
        check("busy_held", {31'd0, busy_ok}, 32'd1);
        check("busy_done_excl", {31'd0, BUSY}, 32'd0);
        check("digits", {16'd0, digits()}, {16'd0, exp_bcd});
        check("ovf", {31'd0, OVF}, {31'd0, exp_ovf});
        $display("conv bin=%0d digits=%h ovf=%0b latency=%0d", v, digits(), OVF, lat);
        tick();
        check("done_pulse", {31'd0, DONE}, 32'd0);
        check("digits_hold", {16'd0, digits()}, {16'd0, exp_bcd});
    endtask

    initial begin
        int          ndone;
        int          done_at;
        int          last_done;
        logic [15:0] got;
        logic        intervals_ok;
        logic        digits_ok;

        vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{14'd9999,  16'h9999, 1'b0};
        vecs[2]  = '{14'd10000, 16'hFFFF, 1'b1};
        vecs[3]  = '{14'd0,     16'h0000, 1'b0};
        vecs[4]  = '{14'd16383, 16'hFFFF, 1'b1};
        vecs[5]  = '{14'd1000,  16'h1000, 1'b0};
        vecs[6]  = '{14'd5678,  16'h5678, 1'b0};
        vecs[7]  = '{14'd9,     16'h0009, 1'b0};
        vecs[8]  = '{14'd10,    16'h0010, 1'b0};
        vecs[9]  = '{14'd4095,  16'h4095, 1'b0};
        vecs[10] = '{14'd8191,  16'h8191, 1'b0};

        // Reset held low two edges
        RESET = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_ovf", {31'd0, OVF}, 32'd0);
        check("rst_digits", {16'd0, digits()}, 32'd0);
        $display("reset digits=%h busy=%0b done=%0b ovf=%0b", digits(), BUSY, DONE, OVF);
        RESET = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        // START pulse with another value while busy must be ignored
        start_conv(14'd1234);
        ndone = 0;
        done_at = -1;
        got = '0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin
                START  = 1'b1;
                BIN_IN = 14'd5678;
            end else if (k == 6) begin
                START = 1'b0;
            end
            tick();
            if (DONE) begin
                ndone++;
                done_at = k;
                got = digits();
            end
        end
        check("busy_start_ndone", ndone, 32'd1);
        check("busy_start_lat", done_at, 32'd14);
        check("busy_start_digits", {16'd0, got}, 32'h1234);
        $display("start-while-busy digits=%h dones=%0d", got, ndone);

        // Reset in the middle of a conversion
        start_conv(14'd4321);
        for (int k = 1; k <= 6; k++) tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_ovf", {31'd0, OVF}, 32'd0);
        check("abort_digits", {16'd0, digits()}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (DONE) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);
        $display("abort digits=%h dones=%0d", digits(), ndone);
        run_vec(14'd42, 16'h0042, 1'b0);

        // START held high: one result every 15 cycles
        START  = 1'b1;
        BIN_IN = 14'd7;
        tick();
        ndone = 0;
        done_at = -1;
        last_done = -1;
        intervals_ok = 1'b1;
        digits_ok = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            if (k == 60) START = 1'b0;
            tick();
            if (DONE) begin
                ndone++;
                if (done_at < 0) done_at = k;
                if (last_done >= 0 && (k - last_done) != 15) intervals_ok = 1'b0;
                if (digits() !== 16'h0007) digits_ok = 1'b0;
                if (BUSY) intervals_ok = 1'b0;
                last_done = k;
                $display("b2b done at cycle %0d digits=%h", k, digits());
            end
        end
        check("b2b_ndone", ndone, 32'd4);
        check("b2b_first", done_at, 32'd14);
        check("b2b_interval", {31'd0, intervals_ok}, 32'd1);
        check("b2b_digits", {31'd0, digits_ok}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
